// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared FSM encodings, stage indices and hazard helpers
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    PHC_RUN       = 2'd0,
    PHC_MEM_WAIT  = 2'd1,
    PHC_MD_WAIT   = 2'd2,
    PHC_TRAP_FILL = 2'd3
  } phc_state_e;

  // Bit positions of the per-stage control vectors.
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  localparam logic [3:0] STALL_ALL = 4'b1111;
  // MEM/WB keeps draining while EX holds the mul/div.
  localparam logic [3:0] STALL_MD  = STALL_ALL & ~(4'b0001 << STG_MEMWB);

  // A load writing x0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic       is_load,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [1:0] used
  );
    return is_load && (rd != 5'd0) &&
           ((used[0] && (rs1 == rd)) || (used[1] && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - width-parameterised saturating up-counter with clear
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment by one, holds at all-ones
//   cnt      : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/issue_select control for the dual-issue core
//   inputs : ID sources, EX dest/load/redirect/kill, MEM req/ack, mul/div start/done, trap
//   outputs: stall/flush/issue_sel per stage (bit0 IF/ID .. bit3 MEM/WB), pc_hold,
//            sticky md_timeout, saturating stall_cnt
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT  = 64,
  parameter int TRAP_REFILL = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [1:0]       id_rs_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_kill_issue1,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             trap,
  output logic [3:0]       stall,
  output logic [3:0]       flush,
  output logic [3:0]       issue_sel,
  output logic             pc_hold,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_CW = (MD_TIMEOUT < 2) ? 1 : $clog2(MD_TIMEOUT + 1);
  localparam int RF_W  = (TRAP_REFILL < 2) ? 1 : $clog2(TRAP_REFILL + 1);

  phc_state_e       state_q, state_d;
  logic [RF_W-1:0]  refill_q, refill_d;
  logic             md_timeout_q, md_timeout_d;
  logic [MD_CW-1:0] md_cnt;
  logic             md_stay;
  logic             md_hit;
  logic             mem_wait;
  logic             load_use;
  logic [3:0]       stall_c, flush_c, isel_c;
  logic             pc_hold_c;

  assign mem_wait = mem_req && !mem_ack;
  assign load_use = load_use_hit(ex_is_load, ex_rd, id_rs1, id_rs2, id_rs_used);

  always_comb begin
    state_d   = state_q;
    refill_d  = refill_q;
    stall_c   = '0;
    flush_c   = '0;
    isel_c    = '0;
    pc_hold_c = 1'b0;
    md_stay   = 1'b0;
    md_hit    = 1'b0;

    if (trap) begin
      flush_c = 4'b1111;
      if (TRAP_REFILL == 0) begin
        state_d = PHC_RUN;
      end else begin
        state_d  = PHC_TRAP_FILL;
        refill_d = RF_W'(TRAP_REFILL);
      end
    end else begin
      case (state_q)
        PHC_TRAP_FILL: begin
          flush_c[STG_IFID] = 1'b1;
          if (refill_q != '0) begin
            refill_d = refill_q - RF_W'(1);
          end
          if (refill_q <= RF_W'(1)) begin
            state_d = PHC_RUN;
          end
        end

        PHC_MD_WAIT: begin
          if (!md_done) begin
            // Still waiting; a memory wait layered on top stalls MEM/WB too.
            md_stay   = 1'b1;
            md_hit    = (int'(md_cnt) + 1) >= MD_TIMEOUT;
            stall_c   = mem_wait ? STALL_ALL : STALL_MD;
            pc_hold_c = 1'b1;
          end else if (md_start) begin
            // Back-to-back op: the wait counter restarts via md_stay = 0.
            stall_c   = mem_wait ? STALL_ALL : STALL_MD;
            pc_hold_c = 1'b1;
          end else if (mem_wait) begin
            stall_c   = STALL_ALL;
            pc_hold_c = 1'b1;
            state_d   = PHC_MEM_WAIT;
          end else begin
            state_d = PHC_RUN;
          end
        end

        default: begin
          if (mem_wait) begin
            stall_c   = STALL_ALL;
            pc_hold_c = 1'b1;
            state_d   = PHC_MEM_WAIT;
          end else if (md_start) begin
            stall_c   = STALL_MD;
            pc_hold_c = 1'b1;
            state_d   = PHC_MD_WAIT;
          end else begin
            state_d = PHC_RUN;
            // Redirect and load-use only act on a free-running pipe, not in
            // the release cycle of a memory wait.
            if (state_q == PHC_RUN) begin
              if (ex_redirect) begin
                flush_c[STG_IFID] = 1'b1;
                flush_c[STG_IDEX] = 1'b1;
              end
              if (ex_kill_issue1) begin
                flush_c[STG_EXMEM] = 1'b1;
                isel_c[STG_EXMEM]  = 1'b1;
              end
              if (load_use && !ex_redirect) begin
                stall_c[STG_IFID] = 1'b1;
                flush_c[STG_IDEX] = 1'b1;
                pc_hold_c         = 1'b1;
              end
            end
          end
        end
      endcase
    end

    md_timeout_d = md_timeout_q | md_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PHC_RUN;
      refill_q     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      refill_q     <= refill_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  sat_counter #(.W(MD_CW)) u_md_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!md_stay),
    .inc (md_stay),
    .cnt (md_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (|stall_c),
    .cnt (stall_cnt)
  );

  // Outputs are forced low for the whole reset window, not just after an edge.
  assign stall      = rst ? 4'b0000 : stall_c;
  assign flush      = rst ? 4'b0000 : flush_c;
  assign issue_sel  = rst ? 4'b0000 : isel_c;
  assign pc_hold    = !rst && pc_hold_c;
  assign md_timeout = !rst && (md_timeout_q || md_hit);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk, rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic [1:0]    id_rs_used;
  logic          ex_is_load, ex_redirect, ex_kill_issue1;
  logic          mem_req, mem_ack, md_start, md_done, trap;
  logic [3:0]    stall, flush, issue_sel;
  logic          pc_hold, md_timeout;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MD_TIMEOUT(4), .TRAP_REFILL(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs_used     (id_rs_used),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .ex_redirect    (ex_redirect),
    .ex_kill_issue1 (ex_kill_issue1),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .md_start       (md_start),
    .md_done        (md_done),
    .trap           (trap),
    .stall          (stall),
    .flush          (flush),
    .issue_sel      (issue_sel),
    .pc_hold        (pc_hold),
    .md_timeout     (md_timeout),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    string         nm;
    logic [3:0]    st, fl, is;
    logic          ph, to;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Expected stall_cnt is the count of stalled cycles before this one.
  task automatic exp_push(input string nm, input logic [3:0] st, input logic [3:0] fl,
                          input logic [3:0] is, input logic ph, input logic to);
    exp_t e;
    e.nm = nm; e.st = st; e.fl = fl; e.is = is; e.ph = ph; e.to = to; e.cnt = exp_cnt;
    sb.push_back(e);
    if (st != 4'b0000 && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs_used = 2'b00; ex_rd = 5'd0;
    ex_is_load = 1'b0; ex_redirect = 1'b0; ex_kill_issue1 = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; md_start = 1'b0; md_done = 1'b0; trap = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".stall"},     32'(stall),       32'(e.st));
      chk({e.nm, ".flush"},     32'(flush),       32'(e.fl));
      chk({e.nm, ".issue_sel"}, 32'(issue_sel),   32'(e.is));
      chk({e.nm, ".pc_hold"},   32'(pc_hold),     32'(e.ph));
      chk({e.nm, ".md_timeout"},32'(md_timeout),  32'(e.to));
      chk({e.nm, ".stall_cnt"}, 32'(stall_cnt),   32'(e.cnt));
      chk({e.nm, ".excl"},      32'(stall & flush), 32'd0);
    end
  end

  initial begin
    rst = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs_used = 2'b00; ex_rd = 5'd0;
    ex_is_load = 1'b0; ex_redirect = 1'b0; ex_kill_issue1 = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; md_start = 1'b0; md_done = 1'b0; trap = 1'b0;
    #2 rst = 1'b1;

    nxt(); mem_req = 1'b1; exp_push("rst_hold", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); rst = 1'b0;     exp_push("idle", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs_used = 2'b01;
    exp_push("lu_rs1", 4'b0001, 4'b0010, 4'h0, 1, 0);
    nxt(); exp_push("lu_done", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs_used = 2'b11;
    exp_push("lu_x0", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs_used = 2'b01;
    exp_push("lu_unused", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs_used = 2'b10;
    exp_push("lu_rs2", 4'b0001, 4'b0010, 4'h0, 1, 0);
    nxt(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs_used = 2'b01; ex_redirect = 1;
    exp_push("lu_redir", 4'h0, 4'b0011, 4'h0, 0, 0);
    nxt(); ex_redirect = 1; ex_kill_issue1 = 1;
    exp_push("redir_kill", 4'h0, 4'b0111, 4'b0100, 0, 0);
    nxt(); ex_kill_issue1 = 1;
    exp_push("kill_only", 4'h0, 4'b0100, 4'b0100, 0, 0);
    nxt(); ex_rd = 5; id_rs1 = 5; id_rs_used = 2'b01;
    exp_push("no_load", 4'h0, 4'h0, 4'h0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      nxt(); mem_req = 1; exp_push("mem_wait", 4'b1111, 4'h0, 4'h0, 1, 0);
    end
    nxt(); mem_req = 1; mem_ack = 1; exp_push("mem_ack", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); exp_push("mem_after", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt(); md_start = 1; exp_push("md_start", 4'b0111, 4'h0, 4'h0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); exp_push("md_wait", 4'b0111, 4'h0, 4'h0, 1, 0);
    end
    nxt(); md_done = 1; exp_push("md_done", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); exp_push("md_after", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt(); mem_req = 1; exp_push("mem_b", 4'b1111, 4'h0, 4'h0, 1, 0);
    nxt(); mem_req = 1; mem_ack = 1; md_start = 1;
    exp_push("ack_md_start", 4'b0111, 4'h0, 4'h0, 1, 0);
    nxt(); exp_push("md_wait_b", 4'b0111, 4'h0, 4'h0, 1, 0);
    nxt(); md_done = 1; exp_push("md_done_b", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt(); md_start = 1; exp_push("md_start_c", 4'b0111, 4'h0, 4'h0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); exp_push("md_wait_c", 4'b0111, 4'h0, 4'h0, 1, 0);
    end
    nxt(); md_done = 1; md_start = 1; exp_push("md_restart", 4'b0111, 4'h0, 4'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); exp_push("md_pre_to", 4'b0111, 4'h0, 4'h0, 1, 0);
    end
    nxt(); exp_push("md_to_hit", 4'b0111, 4'h0, 4'h0, 1, 1);
    nxt(); exp_push("md_to_stay", 4'b0111, 4'h0, 4'h0, 1, 1);
    nxt(); md_done = 1; exp_push("md_to_done", 4'h0, 4'h0, 4'h0, 0, 1);
    nxt(); exp_push("md_to_sticky", 4'h0, 4'h0, 4'h0, 0, 1);

    nxt(); md_start = 1; exp_push("md_start_d", 4'b0111, 4'h0, 4'h0, 1, 1);
    nxt(); exp_push("md_wait_d", 4'b0111, 4'h0, 4'h0, 1, 1);
    nxt(); #2 rst = 1'b1; exp_cnt = '0;
    exp_push("rst_async", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); rst = 1'b0; exp_push("post_rst", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt(); mem_req = 1; exp_push("mem_c", 4'b1111, 4'h0, 4'h0, 1, 0);
    nxt(); mem_req = 1; exp_push("mem_c2", 4'b1111, 4'h0, 4'h0, 1, 0);
    nxt(); mem_req = 1; trap = 1; exp_push("trap", 4'h0, 4'b1111, 4'h0, 0, 0);
    nxt(); mem_req = 1; exp_push("refill1", 4'h0, 4'b0001, 4'h0, 0, 0);
    nxt(); mem_req = 1; exp_push("refill2", 4'h0, 4'b0001, 4'h0, 0, 0);
    nxt(); exp_push("trap_run", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); ex_redirect = 1; exp_push("trap_redir", 4'h0, 4'b0011, 4'h0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      nxt(); mem_req = 1; exp_push("mem_sat", 4'b1111, 4'h0, 4'h0, 1, 0);
    end
    nxt(); mem_req = 1; mem_ack = 1; exp_push("sat_ack", 4'h0, 4'h0, 4'h0, 0, 0);
    nxt(); exp_push("sat_hold", 4'h0, 4'h0, 4'h0, 0, 0);

    nxt();
    nxt();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
